// File: rtl/bomba_pkg.sv
// Shared types and widths for the two-stage bomb password game.
package bomba_pkg;

   localparam int TEMPO_W = 8;
   localparam int TENT_W  = 4;

   typedef enum logic [2:0] {
      IDLE,
      SENHA_A,
      SENHA_B,
      DESARMADA,
      EXPLODIDA
   } estado_t;

   // True while a game is being played (countdown running, guesses accepted).
   function automatic logic em_jogo(input estado_t estado);
      return (estado == SENHA_A) || (estado == SENHA_B);
   endfunction

endpackage

// File: rtl/controlador_senha_if.sv
// Player/board side signals of the password controller.
// The master drives buttons, switches and secrets; the slave is the controller.
interface controlador_senha_if;
   import bomba_pkg::*;

   logic              START;
   logic              ENTER;
   logic [3:0]        TENTATIVA;
   logic [3:0]        SENHA_A_IN;
   logic [2:0]        SENHA_B_IN;
   logic              DICA_ENABLE;
   logic              DICA_STROBE;
   logic              ACERTOU_SENHA_A;
   logic              DESARMADA;
   logic              EXPLODIDA;
   logic [TEMPO_W-1:0] TEMPO_RESTANTE;
   logic [TENT_W-1:0]  TENT_RESTANTES;

   modport master (
      output START, ENTER, TENTATIVA, SENHA_A_IN, SENHA_B_IN,
      input  DICA_ENABLE, DICA_STROBE, ACERTOU_SENHA_A, DESARMADA, EXPLODIDA,
             TEMPO_RESTANTE, TENT_RESTANTES
   );

   modport slave (
      input  START, ENTER, TENTATIVA, SENHA_A_IN, SENHA_B_IN,
      output DICA_ENABLE, DICA_STROBE, ACERTOU_SENHA_A, DESARMADA, EXPLODIDA,
             TEMPO_RESTANTE, TENT_RESTANTES
   );

endinterface

// File: rtl/sincroniza_borda.sv
// Two-flop synchronizer for a raw button followed by a registered rising-edge pulse.
// A held button produces exactly one single-cycle pulse.
module sincroniza_borda (
   input  logic clk,
   input  logic rst_n,
   input  logic botao,
   output logic pulso
);

   logic [2:0] sync_q, sync_d;
   logic       pulso_q, pulso_d;

   // Shift the raw button through the synchronizer and detect a 0->1 on the synchronized copy.
   always_comb begin
      sync_d  = {sync_q[1:0], botao};
      pulso_d = sync_q[1] & ~sync_q[2];
   end

   // Synchronizer and pulse registers, cleared by reset so no stale press survives it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q  <= '0;
         pulso_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         pulso_q <= pulso_d;
      end
   end

   assign pulso = pulso_q;

endmodule

// File: rtl/controlador_senha.sv
// Game sequencer for the two-stage bomb password: latches the secrets on START,
// runs the one-second countdown, tracks remaining attempts and judges ENTER presses.
module controlador_senha
   import bomba_pkg::*;
#(
   parameter int CLK_HZ        = 50_000_000,
   parameter int TEMPO_INICIAL = 60,
   parameter int MAX_TENT      = 8
) (
   input logic               CLOCK,
   input logic               RESET_N,
   controlador_senha_if.slave bus
);

   localparam int                 PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
   localparam logic [TEMPO_W-1:0] TEMPO_INI = TEMPO_W'(TEMPO_INICIAL);
   localparam logic [TENT_W-1:0]  TENT_INI  = TENT_W'(MAX_TENT);

   logic start_pulso;
   logic enter_pulso;

   estado_t            estado_q, estado_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [TEMPO_W-1:0] tempo_q, tempo_d;
   logic [TENT_W-1:0]  tent_q, tent_d;
   logic [3:0]         senha_a_q, senha_a_d;
   logic [2:0]         senha_b_q, senha_b_d;
   logic               acertou_q, acertou_d;
   logic               strobe_q, strobe_d;
   logic               dica_enable_q, dica_enable_d;
   logic               desarmada_q, desarmada_d;
   logic               explodida_q, explodida_d;

   logic jogando;
   logic tick;
   logic acerto;
   logic ganhou;

   sincroniza_borda u_sync_start (
      .clk   (CLOCK),
      .rst_n (RESET_N),
      .botao (bus.START),
      .pulso (start_pulso)
   );

   sincroniza_borda u_sync_enter (
      .clk   (CLOCK),
      .rst_n (RESET_N),
      .botao (bus.ENTER),
      .pulso (enter_pulso)
   );

   // Next-state logic: guess judgement first, then the countdown tick unless the guess just won.
   always_comb begin
      estado_d  = estado_q;
      presc_d   = presc_q;
      tempo_d   = tempo_q;
      tent_d    = tent_q;
      senha_a_d = senha_a_q;
      senha_b_d = senha_b_q;
      acertou_d = acertou_q;
      strobe_d  = 1'b0;
      acerto    = 1'b0;
      ganhou    = 1'b0;
      jogando   = em_jogo(estado_q);
      tick      = jogando && (presc_q == PRESC_MAX);

      if (jogando) begin
         presc_d = tick ? '0 : presc_q + PRESC_W'(1);
      end

      case (estado_q)
         IDLE, DESARMADA, EXPLODIDA: begin
            if (start_pulso) begin
               senha_a_d = bus.SENHA_A_IN;
               senha_b_d = bus.SENHA_B_IN;
               tempo_d   = TEMPO_INI;
               tent_d    = TENT_INI;
               presc_d   = '0;
               acertou_d = 1'b0;
               estado_d  = SENHA_A;
            end
         end
         SENHA_A, SENHA_B: begin
            if (enter_pulso) begin
               if (estado_q == SENHA_A) begin
                  acerto = (bus.TENTATIVA == senha_a_q);
               end else begin
                  acerto = (bus.TENTATIVA == {1'b0, senha_b_q});
               end
               if (acerto) begin
                  if (estado_q == SENHA_A) begin
                     estado_d  = SENHA_B;
                     acertou_d = 1'b1;
                  end else begin
                     estado_d = DESARMADA;
                     ganhou   = 1'b1;
                  end
               end else begin
                  strobe_d = 1'b1;
                  if (tent_q <= TENT_W'(1)) begin
                     tent_d   = '0;
                     estado_d = EXPLODIDA;
                  end else begin
                     tent_d = tent_q - TENT_W'(1);
                  end
               end
            end
            if (tick && !ganhou) begin
               if (tempo_q <= TEMPO_W'(1)) begin
                  tempo_d  = '0;
                  estado_d = EXPLODIDA;
               end else begin
                  tempo_d = tempo_q - TEMPO_W'(1);
               end
            end
         end
         default: estado_d = IDLE;
      endcase

      dica_enable_d = em_jogo(estado_d);
      desarmada_d   = (estado_d == DESARMADA);
      explodida_d   = (estado_d == EXPLODIDA);
   end

   // FSM state register with the registered status outputs that follow it.
   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         estado_q      <= IDLE;
         dica_enable_q <= 1'b0;
         strobe_q      <= 1'b0;
         acertou_q     <= 1'b0;
         desarmada_q   <= 1'b0;
         explodida_q   <= 1'b0;
      end else begin
         estado_q      <= estado_d;
         dica_enable_q <= dica_enable_d;
         strobe_q      <= strobe_d;
         acertou_q     <= acertou_d;
         desarmada_q   <= desarmada_d;
         explodida_q   <= explodida_d;
      end
   end

   // One-second prescaler and the remaining-time counter.
   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         presc_q <= '0;
         tempo_q <= '0;
      end else begin
         presc_q <= presc_d;
         tempo_q <= tempo_d;
      end
   end

   // Attempt counter and the secrets latched at the start of each game.
   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         tent_q    <= '0;
         senha_a_q <= '0;
         senha_b_q <= '0;
      end else begin
         tent_q    <= tent_d;
         senha_a_q <= senha_a_d;
         senha_b_q <= senha_b_d;
      end
   end

   assign bus.DICA_ENABLE     = dica_enable_q;
   assign bus.DICA_STROBE     = strobe_q;
   assign bus.ACERTOU_SENHA_A = acertou_q;
   assign bus.DESARMADA       = desarmada_q;
   assign bus.EXPLODIDA       = explodida_q;
   assign bus.TEMPO_RESTANTE  = tempo_q;
   assign bus.TENT_RESTANTES  = tent_q;

endmodule

// File: tb/tb_controlador_senha.sv
// Bench for controlador_senha: a game-rule reference model predicts the outputs after
// every clock edge into a queue, and a monitor pops and compares them against the DUT.
module tb_controlador_senha;

   localparam int CLK_HZ        = 10;
   localparam int TEMPO_INICIAL = 5;
   localparam int MAX_TENT      = 3;
   localparam int BTN_LAT       = 3;
   localparam int MAX_CYCLES    = 60000;

   localparam int F_IDLE = 0;
   localparam int F_A    = 1;
   localparam int F_B    = 2;
   localparam int F_WON  = 3;
   localparam int F_LOST = 4;

   typedef struct packed {
      logic       en;
      logic       st;
      logic       ac;
      logic       des;
      logic       exp;
      logic [7:0] tempo;
      logic [3:0] tent;
   } saida_t;

   logic CLOCK;
   logic RESET_N;

   controlador_senha_if bus ();

   controlador_senha #(
      .CLK_HZ        (CLK_HZ),
      .TEMPO_INICIAL (TEMPO_INICIAL),
      .MAX_TENT      (MAX_TENT)
   ) dut (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   saida_t esperado_q[$];
   int     tests_run    = 0;
   int     tests_failed = 0;
   int     cyc          = 0;

   int m_fase       = F_IDLE;
   int m_tempo      = 0;
   int m_tent       = 0;
   int m_seg        = 0;
   int m_a          = 0;
   int m_b          = 0;
   bit m_acertou    = 1'b0;
   bit m_prev_start = 1'b0;
   bit m_prev_enter = 1'b0;
   int start_ev_q[$];
   int enter_ev_q[$];
   bit m_start_ev, m_enter_ev, m_tick, m_won, m_strobe, m_playing;

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   // Reference model: applies the game rules once per clock edge and queues the expected outputs.
   always @(posedge CLOCK) begin : modelo
      saida_t e;
      cyc        = cyc + 1;
      m_start_ev = 1'b0;
      m_enter_ev = 1'b0;
      m_strobe   = 1'b0;
      if (RESET_N !== 1'b1) begin
         m_fase       = F_IDLE;
         m_tempo      = 0;
         m_tent       = 0;
         m_seg        = 0;
         m_a          = 0;
         m_b          = 0;
         m_acertou    = 1'b0;
         m_prev_start = 1'b0;
         m_prev_enter = 1'b0;
         start_ev_q.delete();
         enter_ev_q.delete();
      end else begin
         if (start_ev_q.size() > 0 && start_ev_q[0] == cyc) begin
            m_start_ev = 1'b1;
            void'(start_ev_q.pop_front());
         end
         if (enter_ev_q.size() > 0 && enter_ev_q[0] == cyc) begin
            m_enter_ev = 1'b1;
            void'(enter_ev_q.pop_front());
         end
         if (bus.START && !m_prev_start) start_ev_q.push_back(cyc + BTN_LAT);
         if (bus.ENTER && !m_prev_enter) enter_ev_q.push_back(cyc + BTN_LAT);
         m_prev_start = bus.START;
         m_prev_enter = bus.ENTER;

         m_playing = (m_fase == F_A) || (m_fase == F_B);
         m_tick    = 1'b0;
         if (m_playing) begin
            if (m_seg == CLK_HZ - 1) begin
               m_tick = 1'b1;
               m_seg  = 0;
            end else begin
               m_seg = m_seg + 1;
            end
         end

         if (!m_playing) begin
            if (m_start_ev) begin
               m_a       = int'(bus.SENHA_A_IN);
               m_b       = int'(bus.SENHA_B_IN);
               m_tempo   = TEMPO_INICIAL;
               m_tent    = MAX_TENT;
               m_seg     = 0;
               m_acertou = 1'b0;
               m_fase    = F_A;
            end
         end else begin
            m_won = 1'b0;
            if (m_enter_ev) begin
               if (m_fase == F_A && int'(bus.TENTATIVA) == m_a) begin
                  m_fase    = F_B;
                  m_acertou = 1'b1;
               end else if (m_fase == F_B && int'(bus.TENTATIVA) == m_b) begin
                  m_fase = F_WON;
                  m_won  = 1'b1;
               end else begin
                  m_strobe = 1'b1;
                  m_tent   = m_tent - 1;
                  if (m_tent == 0) m_fase = F_LOST;
               end
            end
            if (m_tick && !m_won) begin
               m_tempo = m_tempo - 1;
               if (m_tempo == 0) m_fase = F_LOST;
            end
         end
      end
      e.en    = (m_fase == F_A) || (m_fase == F_B);
      e.st    = m_strobe;
      e.ac    = m_acertou;
      e.des   = (m_fase == F_WON);
      e.exp   = (m_fase == F_LOST);
      e.tempo = 8'(m_tempo);
      e.tent  = 4'(m_tent);
      esperado_q.push_back(e);
   end

   // Compares one predicted output set against what the DUT presents.
   task automatic check_output(input saida_t e);
      saida_t got;
      got.en    = bus.DICA_ENABLE;
      got.st    = bus.DICA_STROBE;
      got.ac    = bus.ACERTOU_SENHA_A;
      got.des   = bus.DESARMADA;
      got.exp   = bus.EXPLODIDA;
      got.tempo = bus.TEMPO_RESTANTE;
      got.tent  = bus.TENT_RESTANTES;
      tests_run = tests_run + 1;
      if (got !== e) begin
         tests_failed = tests_failed + 1;
         $display("[TB] FAIL cycle %0d outputs: got en=%0b st=%0b ac=%0b des=%0b exp=%0b tempo=%0d tent=%0d, expected en=%0b st=%0b ac=%0b des=%0b exp=%0b tempo=%0d tent=%0d",
                  cyc, got.en, got.st, got.ac, got.des, got.exp, got.tempo, got.tent,
                  e.en, e.st, e.ac, e.des, e.exp, e.tempo, e.tent);
      end
   endtask

   // Monitor: outputs settle after the rising edge, so check them on the falling edge.
   always @(negedge CLOCK) begin
      if (esperado_q.size() > 0) check_output(esperado_q.pop_front());
   end

   task automatic idle(input int n);
      repeat (n) @(negedge CLOCK);
   endtask

   task automatic reset_dut(input int n);
      @(negedge CLOCK);
      RESET_N = 1'b0;
      repeat (n) @(negedge CLOCK);
      RESET_N = 1'b1;
   endtask

   // Press START; ev returns the edge at which the controller reacts to it.
   task automatic press_start(output int ev);
      @(negedge CLOCK);
      bus.START = 1'b1;
      ev = cyc + 1 + BTN_LAT;
      repeat (2) @(negedge CLOCK);
      bus.START = 1'b0;
      idle(4);
   endtask

   // Press ENTER with a guess, holding it for the given number of cycles.
   task automatic press_enter(input logic [3:0] guess, input int hold);
      @(negedge CLOCK);
      bus.TENTATIVA = guess;
      bus.ENTER     = 1'b1;
      repeat (hold) @(negedge CLOCK);
      bus.ENTER = 1'b0;
      idle(4);
   endtask

   task automatic apply_stimulus();
      int ev;
      int sa, sb, guess;

      reset_dut(3);
      idle(2);

      // Full win: A then B, no strobes.
      bus.SENHA_A_IN = 4'd9;
      bus.SENHA_B_IN = 3'd5;
      press_start(ev);
      press_enter(4'd9, 1);
      press_enter(4'd5, 1);
      idle(5);

      // Three misses in stage A explode the bomb.
      press_start(ev);
      press_enter(4'd2, 1);
      press_enter(4'd3, 1);
      press_enter(4'd4, 1);
      idle(5);

      // Guess above 7 in stage B is always wrong; then reset mid-game.
      press_start(ev);
      press_enter(4'd9, 1);
      press_enter(4'd12, 2);
      idle(3);
      reset_dut(2);
      idle(3);

      // Countdown to expiry with no guesses.
      press_start(ev);
      idle(60);

      // Correct B guess landing exactly on the expiry tick.
      press_start(ev);
      press_enter(4'd9, 1);
      while (cyc < ev + TEMPO_INICIAL * CLK_HZ - 1 - BTN_LAT) @(negedge CLOCK);
      bus.TENTATIVA = 4'd5;
      bus.ENTER     = 1'b1;
      @(negedge CLOCK);
      bus.ENTER = 1'b0;
      idle(10);

      // Held ENTER judged once; START during play ignored.
      press_start(ev);
      press_start(ev);
      press_enter(4'd9, 1);
      press_enter(4'd3, 20);
      idle(60);

      // Randomized games with random secrets, guesses, timing, restarts and resets.
      for (int g = 0; g < 30; g++) begin
         sa = int'($urandom_range(0, 15));
         sb = int'($urandom_range(0, 7));
         bus.SENHA_A_IN = 4'(sa);
         bus.SENHA_B_IN = 3'(sb);
         press_start(ev);
         bus.SENHA_A_IN = 4'($urandom_range(0, 15));
         bus.SENHA_B_IN = 3'($urandom_range(0, 7));
         for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 3) == 0) guess = int'($urandom_range(0, 15));
            else guess = (m_fase == F_B) ? sb : sa;
            press_enter(4'(guess), int'($urandom_range(1, 5)));
            idle(int'($urandom_range(0, 12)));
            if ($urandom_range(0, 19) == 0) press_start(ev);
            if ($urandom_range(0, 24) == 0) reset_dut(int'($urandom_range(1, 2)));
         end
         idle(int'($urandom_range(0, 8)));
      end
      idle(5);
   endtask

   initial begin
      RESET_N        = 1'b0;
      bus.START      = 1'b0;
      bus.ENTER      = 1'b0;
      bus.TENTATIVA  = 4'd0;
      bus.SENHA_A_IN = 4'd0;
      bus.SENHA_B_IN = 3'd0;
      apply_stimulus();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Cycle budget guard so the run always ends with a summary.
   initial begin
      repeat (MAX_CYCLES) @(posedge CLOCK);
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL watchdog: got %0d cycles without finishing, required fewer", MAX_CYCLES);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
